sram_march_bist: RTL

- Built-in self-test initiator for the dual-port generic SRAM macros (GSRAM_<depth>x<width> family). It drives both ports of one macro.
- Runs a March C- sequence on port 0, then a read-only sweep on port 1, and compares read data against expected values.
- Reports pass/fail, plus the first failing address and element.
- Sits between the tile test controller (start/done handshake) and the SRAM wrapper, muxed ahead of functional traffic.

---
 rtl/sram_march_bist.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for a dual-port generic SRAM: e0..e5 run on port 0,
// e6 is a read-only sweep on port 1. The first mismatch's address and element are captured.
module sram_march_bist #(
   parameter int ABITS  = 14,
   parameter int DBITS  = 1,
   parameter int RD_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ABITS-1:0] fail_addr,
   output logic [2:0]       fail_elem,
   output logic [ABITS-1:0] A0,
   output logic [DBITS-1:0] D0,
   output logic             WE0,
   output logic             CE0,
   input  logic [DBITS-1:0] Q0,
   output logic [ABITS-1:0] A1,
   output logic [DBITS-1:0] D1,
   output logic             WE1,
   output logic             CE1,
   input  logic [DBITS-1:0] Q1
);
   localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             vld;
      logic             expv;
      logic             port;
      logic [2:0]       elem;
      logic [ABITS-1:0] addr;
   } rd_tag_t;

   state_t           state;
   logic [2:0]       op_elem;
   logic [ABITS-1:0] op_addr;
   logic             op_wr;
   logic             failed;
   logic [DCW-1:0]   drain_cnt;
   rd_tag_t          pipe [RD_LAT];

   logic             up;
   logic             pair;
   logic             last_addr;
   logic             seq_end;
   logic [2:0]       nxt_elem;
   logic [ABITS-1:0] nxt_addr;
   logic             nxt_wr;
   logic             accept;
   logic             issue_en;
   logic [2:0]       iss_elem;
   logic [ABITS-1:0] iss_addr;
   logic             iss_wr;
   rd_tag_t          tail;
   logic [DBITS-1:0] tail_q;
   logic             mismatch;

   assign D1  = '0;
   assign WE1 = 1'b0;

   // Successor of the operation currently on the ports. Pair elements visit each
   // address twice (read then write); an element ends at its last address only.
   always_comb begin
      up        = (op_elem != 3'd3) && (op_elem != 3'd4);
      pair      = (op_elem >= 3'd1) && (op_elem <= 3'd4);
      last_addr = up ? (&op_addr) : (op_addr == '0);
      nxt_elem  = op_elem;
      nxt_addr  = op_addr;
      nxt_wr    = 1'b0;
      seq_end   = 1'b0;
      if (pair && !op_wr) begin
         nxt_wr = 1'b1;
      end else if (!last_addr) begin
         nxt_addr = up ? (op_addr + ABITS'(1)) : (op_addr - ABITS'(1));
         nxt_wr   = (op_elem == 3'd0);
      end else if (op_elem == 3'd6) begin
         seq_end = 1'b1;
      end else begin
         nxt_elem = op_elem + 3'd1;
         nxt_addr = ((op_elem == 3'd2) || (op_elem == 3'd3)) ? '1 : '0;
      end
   end

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign issue_en = accept || ((state == RUN) && !mismatch && !seq_end);
   assign iss_elem = accept ? 3'd0 : nxt_elem;
   assign iss_addr = accept ? '0 : nxt_addr;
   assign iss_wr   = accept ? 1'b1 : nxt_wr;

   assign tail     = pipe[RD_LAT-1];
   assign tail_q   = tail.port ? Q1 : Q0;
   assign mismatch = tail.vld && !failed && (tail_q != {DBITS{tail.expv}});

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         op_elem   <= '0;
         op_addr   <= '0;
         op_wr     <= 1'b0;
         failed    <= 1'b0;
         drain_cnt <= '0;
         A0        <= '0;
         D0        <= '0;
         WE0       <= 1'b0;
         CE0       <= 1'b0;
         A1        <= '0;
         CE1       <= 1'b0;
      end else begin
         if (mismatch) begin
            failed    <= 1'b1;
            fail_addr <= tail.addr;
            fail_elem <= tail.elem;
         end
         if (issue_en) begin
            op_elem <= iss_elem;
            op_addr <= iss_addr;
            op_wr   <= iss_wr;
            A0      <= iss_addr;
            A1      <= iss_addr;
            WE0     <= iss_wr;
            CE0     <= (iss_elem != 3'd6);
            CE1     <= (iss_elem == 3'd6);
            D0      <= {DBITS{iss_wr & iss_elem[0]}};
         end
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  failed    <= 1'b0;
                  fail_addr <= '0;
                  fail_elem <= '0;
               end
            end
            RUN: begin
               if (mismatch || seq_end) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                  CE0       <= 1'b0;
                  WE0       <= 1'b0;
                  CE1       <= 1'b0;
               end
            end
            DRAIN: begin
               // Reads still in flight are compared here; only a first failure is kept.
               if (drain_cnt == DCW'(RD_LAT - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !(failed || mismatch);
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read tags travel alongside the SRAM read latency so the tail lines up with Q.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{vld:  (state == RUN) && !op_wr,
                      expv: (op_elem == 3'd2) || (op_elem == 3'd4),
                      port: (op_elem == 3'd6),
                      elem: op_elem,
                      addr: op_addr};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

endmodule
